// File: rtl/rename_stage.sv
// ============================================================================
// Module   : rename_stage
// Purpose  : WIDTH-wide register rename stage feeding from a multi-I/O free
//            list; owns the RAT and a registered, back-pressured output group.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rename_stage #(
  parameter  int WIDTH     = 3,
  parameter  int ARCH_REGS = 32,
  parameter  int PHYS_REGS = 64,
  localparam int AR_BITS   = $clog2(ARCH_REGS),
  localparam int PR_BITS   = $clog2(PHYS_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           i_valid,
  input  logic [WIDTH-1:0]           i_has_dst,
  input  logic [WIDTH*AR_BITS-1:0]   i_rd,
  input  logic [WIDTH*AR_BITS-1:0]   i_rs1,
  input  logic [WIDTH*AR_BITS-1:0]   i_rs2,
  output logic                       o_in_ready,
  output logic [WIDTH-1:0]           o_fl_get_en,
  input  logic [WIDTH*PR_BITS-1:0]   i_fl_gotten,
  input  logic [PR_BITS:0]           i_fl_len,
  output logic [WIDTH-1:0]           o_valid,
  output logic [WIDTH-1:0]           o_has_dst,
  output logic [WIDTH*PR_BITS-1:0]   o_prd,
  output logic [WIDTH*PR_BITS-1:0]   o_old_prd,
  output logic [WIDTH*PR_BITS-1:0]   o_prs1,
  output logic [WIDTH*PR_BITS-1:0]   o_prs2,
  input  logic                       i_out_ready,
  output logic                       o_init_done
);

  localparam logic [AR_BITS:0] C_ARCH_REGS = (AR_BITS+1)'(ARCH_REGS);
  localparam logic [AR_BITS:0] C_WIDTH     = (AR_BITS+1)'(WIDTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [AR_BITS:0]       r_init_ptr, w_init_ptr_nxt;
  logic                   r_init_done;
  logic [PR_BITS-1:0]     r_rat [ARCH_REGS];

  logic [WIDTH-1:0]       r_valid, r_has_dst;
  logic [WIDTH*PR_BITS-1:0] r_prd, r_old_prd, r_prs1, r_prs2;

  logic [AR_BITS:0]       w_remain, w_init_n;
  logic [PR_BITS:0]       w_init_n_ext, w_need;
  logic                   w_init_go, w_accept, w_any_out;
  logic [WIDTH-1:0]       w_get_en;

  logic [AR_BITS-1:0]     w_rd [WIDTH];
  logic [AR_BITS-1:0]     w_rs1 [WIDTH];
  logic [AR_BITS-1:0]     w_rs2 [WIDTH];
  logic [PR_BITS-1:0]     w_got [WIDTH];
  logic [PR_BITS-1:0]     w_prs1 [WIDTH];
  logic [PR_BITS-1:0]     w_prs2 [WIDTH];
  logic [PR_BITS-1:0]     w_old [WIDTH];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_unpack
    assign w_rd[gi]  = i_rd[gi*AR_BITS +: AR_BITS];
    assign w_rs1[gi] = i_rs1[gi*AR_BITS +: AR_BITS];
    assign w_rs2[gi] = i_rs2[gi*AR_BITS +: AR_BITS];
    assign w_got[gi] = i_fl_gotten[gi*PR_BITS +: PR_BITS];
  end

  // Get enables are gated by rst_n so the free list sees nothing while reset is held.
  always_comb begin : p_fsm
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    w_init_go      = 1'b0;
    w_accept       = 1'b0;
    w_get_en       = '0;
    o_in_ready     = 1'b0;
    w_remain       = C_ARCH_REGS - r_init_ptr;
    w_init_n       = (w_remain < C_WIDTH) ? w_remain : C_WIDTH;
    w_init_n_ext   = {{(PR_BITS-AR_BITS){1'b0}}, w_init_n};
    w_any_out      = |r_valid;
    w_need         = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_need = w_need + {{PR_BITS{1'b0}}, i_valid[i] & i_has_dst[i]};
    end
    case (r_state)
      ST_INIT: begin
        w_init_go = rst_n && (i_fl_len >= w_init_n_ext);
        if (w_init_go) begin
          w_init_ptr_nxt = r_init_ptr + w_init_n;
          if (w_init_ptr_nxt == C_ARCH_REGS) begin
            w_state_nxt = ST_RUN;
          end
        end
        for (int i = 0; i < WIDTH; i++) begin
          w_get_en[i] = w_init_go && ((AR_BITS+1)'(i) < w_init_n);
        end
      end
      ST_RUN: begin
        o_in_ready = (!w_any_out || i_out_ready) && (i_fl_len >= w_need);
        w_accept   = rst_n && o_in_ready && (|i_valid);
        w_get_en   = w_accept ? (i_valid & i_has_dst) : '0;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign o_fl_get_en = w_get_en;

  // Later slots in the group see the newest earlier writer of the same register.
  always_comb begin : p_rename
    for (int i = 0; i < WIDTH; i++) begin
      w_prs1[i] = r_rat[w_rs1[i]];
      w_prs2[i] = r_rat[w_rs2[i]];
      w_old[i]  = r_rat[w_rd[i]];
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && i_valid[j] && i_has_dst[j]) begin
          if (w_rd[j] == w_rs1[i]) w_prs1[i] = w_got[j];
          if (w_rd[j] == w_rs2[i]) w_prs2[i] = w_got[j];
          if (w_rd[j] == w_rd[i])  w_old[i]  = w_got[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_init_ptr  <= '0;
      r_init_done <= 1'b0;
      r_valid     <= '0;
      r_has_dst   <= '0;
      r_prd       <= '0;
      r_old_prd   <= '0;
      r_prs1      <= '0;
      r_prs2      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_ptr  <= w_init_ptr_nxt;
      r_init_done <= r_init_done | ((r_state == ST_INIT) && (w_state_nxt == ST_RUN));
      if (w_accept) begin
        r_valid   <= i_valid;
        r_has_dst <= i_has_dst;
        for (int i = 0; i < WIDTH; i++) begin
          r_prd[i*PR_BITS +: PR_BITS]     <= w_got[i];
          r_old_prd[i*PR_BITS +: PR_BITS] <= w_old[i];
          r_prs1[i*PR_BITS +: PR_BITS]    <= w_prs1[i];
          r_prs2[i*PR_BITS +: PR_BITS]    <= w_prs2[i];
        end
      end else if (i_out_ready) begin
        r_valid <= '0;
      end
    end
  end

  // RAT has no reset; it is fully rewritten by INIT. Ascending order lets the highest slot win.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (r_state == ST_INIT && w_get_en[i]) begin
        r_rat[r_init_ptr[AR_BITS-1:0] + AR_BITS'(i)] <= w_got[i];
      end
      if (r_state == ST_RUN && w_get_en[i]) begin
        r_rat[w_rd[i]] <= w_got[i];
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_has_dst   = r_has_dst;
  assign o_prd       = r_prd;
  assign o_old_prd   = r_old_prd;
  assign o_prs1      = r_prs1;
  assign o_prs2      = r_prs2;
  assign o_init_done = r_init_done;

endmodule

`default_nettype wire
